// File: rtl/sisc_exec_core.sv
// Execution core for the SISC processor: multi-cycle controller FSM plus a
// 32-bit ALU with C/V/N/Z flag generation and write-back source mux.
module sisc_exec_core (
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] instruction,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [3:0]  stat_cur,
    input  logic [31:0] mem_data,
    output logic [1:0]  alu_op,
    output logic [31:0] alu_result,
    output logic [3:0]  stat,
    output logic        stat_en,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [31:0] write_data,
    output logic        halted
);

    // state     | meaning
    // START0    | first cycle after reset
    // START1    | second cycle after reset
    // FETCH     | instruction presented by the environment
    // DECODE    | opcode decoded, alu_op loaded
    // EXECUTE   | ALU result valid, status register loaded
    // MEM       | memory access slot (unused by current opcodes)
    // WRITEBACK | register file written
    // HALT      | HALT executed; parked until reset
    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_ALU  = 4'b0001;
    localparam logic [3:0] OP_IMM  = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] FN_ADD = 4'b0001;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_NOT = 4'b0011;
    localparam logic [3:0] FN_OR  = 4'b0100;
    localparam logic [3:0] FN_AND = 4'b0101;
    localparam logic [3:0] FN_XOR = 4'b0110;
    localparam logic [3:0] FN_SHL = 4'b0111;
    localparam logic [3:0] FN_SHR = 4'b1000;

    state_t      state;
    logic [3:0]  opcode;
    logic [3:0]  func;
    logic [31:0] imm_ext;
    logic        func_valid;
    logic        writes_ok;
    logic [1:0]  dec_alu_op;

    // Status and register-specifier fields are decoded elsewhere in the pipeline.
    logic        unused_ok;
    assign unused_ok = ^{stat_cur, instruction[27:16]};

    assign opcode     = instruction[31:28];
    assign func       = instruction[3:0];
    assign imm_ext    = {{16{instruction[15]}}, instruction[15:0]};
    assign func_valid = (func != 4'd0) && (func <= FN_SHR);
    assign writes_ok  = ((opcode == OP_ALU) && func_valid) || (opcode == OP_IMM);
    assign dec_alu_op = (opcode == OP_IMM) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state   <= S_START0;
            alu_op  <= 2'b00;
            stat_en <= 1'b0;
            rf_we   <= 1'b0;
            wb_sel  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            stat_en <= 1'b0;
            rf_we   <= 1'b0;
            wb_sel  <= 1'b0;
            case (state)
                S_START0: state <= S_START1;
                S_START1: state <= S_FETCH;
                S_FETCH: begin
                    state  <= S_DECODE;
                    alu_op <= dec_alu_op;
                end
                S_DECODE: begin
                    if (opcode == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        alu_op <= 2'b00;
                    end else begin
                        state   <= S_EXECUTE;
                        stat_en <= writes_ok;
                    end
                end
                S_EXECUTE: state <= S_MEM;
                S_MEM: begin
                    state <= S_WRITEBACK;
                    rf_we <= writes_ok;
                end
                S_WRITEBACK: begin
                    state  <= S_FETCH;
                    alu_op <= 2'b00;
                end
                S_HALT: state <= S_HALT;
                default: begin
                    state  <= S_START0;
                    alu_op <= 2'b00;
                end
            endcase
        end
    end

    logic [32:0] sum_ext;
    logic [31:0] diff;
    logic        flag_c;
    logic        flag_v;

    assign sum_ext = {1'b0, rsa} + {1'b0, rsb};
    assign diff    = rsa - rsb;

    always_comb begin
        alu_result = 32'd0;
        flag_c     = 1'b0;
        flag_v     = 1'b0;
        case (alu_op)
            2'b00: begin
                case (func)
                    FN_ADD: begin
                        alu_result = sum_ext[31:0];
                        flag_c     = sum_ext[32];
                        flag_v     = (rsa[31] == rsb[31]) && (sum_ext[31] != rsa[31]);
                    end
                    FN_SUB: begin
                        alu_result = diff;
                        flag_c     = (rsa >= rsb);
                        flag_v     = (rsa[31] != rsb[31]) && (diff[31] != rsa[31]);
                    end
                    FN_NOT: alu_result = ~rsa;
                    FN_OR:  alu_result = rsa | rsb;
                    FN_AND: alu_result = rsa & rsb;
                    FN_XOR: alu_result = rsa ^ rsb;
                    FN_SHL: alu_result = rsa << rsb[4:0];
                    FN_SHR: alu_result = rsa >> rsb[4:0];
                    default: alu_result = 32'd0;
                endcase
            end
            2'b01:   alu_result = rsa + imm_ext;
            2'b10:   alu_result = rsb;
            default: alu_result = 32'd0;
        endcase
    end

    assign stat       = {flag_c, flag_v, alu_result[31], (alu_result == 32'd0)};
    assign write_data = wb_sel ? mem_data : alu_result;

endmodule

// File: tb/tb_sisc_exec_core.sv
// Directed bench for sisc_exec_core: walks instructions through the
// five-cycle FETCH..WRITEBACK sequence and checks ALU, flags and enables.
module tb_sisc_exec_core;

    logic        clk;
    logic        rst_f;
    logic [31:0] instruction;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  stat_cur;
    logic [31:0] mem_data;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic        stat_en;
    logic        rf_we;
    logic        wb_sel;
    logic [31:0] write_data;
    logic        halted;

    int total = 0;
    int passed = 0;

    sisc_exec_core dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .instruction (instruction),
        .rsa         (rsa),
        .rsb         (rsb),
        .stat_cur    (stat_cur),
        .mem_data    (mem_data),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .stat        (stat),
        .stat_en     (stat_en),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .write_data  (write_data),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset for two cycles, then release; returns at the negedge inside FETCH.
    task automatic do_reset(input string tag);
        rst_f = 1'b1;
        tick();
        tick();
        chk({tag, "_ctrl"}, {27'd0, alu_op, stat_en, rf_we, wb_sel, halted}, 32'd0);
        rst_f = 1'b0;
        tick();
        tick();
    endtask

    // Called at the FETCH negedge; runs one full instruction back to FETCH.
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic [3:0] exp_stat,
                             input logic exp_en, input logic [1:0] exp_op);
        int se_cnt;
        int we_cnt;
        se_cnt = 0;
        we_cnt = 0;
        instruction = ins;
        rsa = a;
        rsb = b;
        for (int c = 1; c <= 5; c++) begin
            tick();
            se_cnt += int'(stat_en);
            we_cnt += int'(rf_we);
            if (c == 2) begin
                chk({tag, "_result"}, alu_result, exp_res);
                chk({tag, "_stat"}, {28'd0, stat}, {28'd0, exp_stat});
                chk({tag, "_stat_en"}, {31'd0, stat_en}, {31'd0, exp_en});
                chk({tag, "_alu_op"}, {30'd0, alu_op}, {30'd0, exp_op});
            end
            if (c == 4) begin
                chk({tag, "_rf_we"}, {31'd0, rf_we}, {31'd0, exp_en});
                chk({tag, "_wdata"}, write_data, exp_res);
                chk({tag, "_wb_sel"}, {31'd0, wb_sel}, 32'd0);
            end
        end
        chk({tag, "_se_pulses"}, se_cnt, exp_en ? 32'd1 : 32'd0);
        chk({tag, "_we_pulses"}, we_cnt, exp_en ? 32'd1 : 32'd0);
    endtask

    initial begin
        int bad;
        rst_f       = 1'b1;
        instruction = 32'h1000_0001;
        rsa         = 32'd5;
        rsb         = 32'd3;
        stat_cur    = 4'h0;
        mem_data    = 32'hDEAD_BEEF;

        // ALU stays combinational while reset is held.
        tick();
        chk("reset_comb_result", alu_result, 32'd8);
        do_reset("reset");

        run_instr("add_5_3",   32'h1000_0001, 32'd5,        32'd3,        32'd8,        4'b0000, 1'b1, 2'b00);
        run_instr("sub_3_5",   32'h1000_0002, 32'd3,        32'd5,        32'hFFFF_FFFE, 4'b0010, 1'b1, 2'b00);
        run_instr("sub_7_7",   32'h1000_0002, 32'd7,        32'd7,        32'd0,        4'b1001, 1'b1, 2'b00);
        run_instr("add_ovf",   32'h1000_0001, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 4'b0110, 1'b1, 2'b00);
        run_instr("add_carry", 32'h1000_0001, 32'hFFFF_FFFF, 32'd1,       32'd0,        4'b1001, 1'b1, 2'b00);
        run_instr("not_zero",  32'h1000_0003, 32'd0,        32'd9,        32'hFFFF_FFFF, 4'b0010, 1'b1, 2'b00);
        run_instr("or",        32'h1000_0004, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000, 1'b1, 2'b00);
        run_instr("and",       32'h1000_0005, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000, 1'b1, 2'b00);
        run_instr("xor",       32'h1000_0006, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0,       4'b0001, 1'b1, 2'b00);
        run_instr("shl_31",    32'h1000_0007, 32'd1,        32'h0000_003F, 32'h8000_0000, 4'b0010, 1'b1, 2'b00);
        run_instr("shr_4",     32'h1000_0008, 32'h8000_0000, 32'd4,       32'h0800_0000, 4'b0000, 1'b1, 2'b00);
        run_instr("imm_neg1",  32'h2000_FFFF, 32'd16,       32'd99,       32'h0000_000F, 4'b0000, 1'b1, 2'b01);
        run_instr("nop",       32'h0000_0000, 32'd5,        32'd3,        32'd0,        4'b0001, 1'b0, 2'b00);
        run_instr("bad_func",  32'h1000_000F, 32'd5,        32'd3,        32'd0,        4'b0001, 1'b0, 2'b00);
        run_instr("other_op",  32'h5000_0000, 32'd5,        32'd3,        32'd0,        4'b0001, 1'b0, 2'b00);

        // Reset during EXECUTE must suppress the pending write-back.
        instruction = 32'h1000_0001;
        rsa = 32'd5;
        rsb = 32'd3;
        bad = 0;
        tick();
        tick();
        chk("abort_in_execute", {31'd0, stat_en}, 32'd1);
        rst_f = 1'b1;
        tick();
        bad += int'(rf_we);
        tick();
        bad += int'(rf_we);
        rst_f = 1'b0;
        tick();
        bad += int'(rf_we);
        tick();
        bad += int'(rf_we);
        chk("abort_no_rf_we", bad, 32'd0);
        run_instr("after_abort", 32'h1000_0001, 32'd5, 32'd3, 32'd8, 4'b0000, 1'b1, 2'b00);

        // HALT: flag rises the cycle after DECODE and sticks until reset.
        instruction = 32'hF000_0000;
        tick();
        chk("halt_in_decode", {31'd0, halted}, 32'd0);
        tick();
        chk("halt_set", {31'd0, halted}, 32'd1);
        instruction = 32'h1000_0001;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!halted || stat_en || rf_we || alu_op != 2'b00) bad++;
        end
        chk("halt_hold", bad, 32'd0);
        do_reset("halt_reset");
        chk("halt_cleared", {31'd0, halted}, 32'd0);
        run_instr("restart_add", 32'h1000_0001, 32'd5, 32'd3, 32'd8, 4'b0000, 1'b1, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sisc_exec_core.md
SISC_EXEC_CORE -- requirements
Module: sisc_exec_core

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_f  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 instruction  input  32  current instruction; opcode [31:28], mm [27:24], rd [23:20], rs [19:16], rt [15:12], imm [15:0], func [3:0]; held stable by the environment for a whole instruction.
REQ-005 rsa  input  32  register-file read data for rs.
REQ-006 rsb  input  32  register-file read data for rt/rd.
REQ-007 stat_cur  input  4  current status-register contents, used by the controller only.
REQ-008 mem_data  input  32  memory read data, the alternate write-back source.
REQ-009 alu_op  output  2  ALU mode driven by the controller.
REQ-010 alu_result  output  32  ALU result, combinational.
REQ-011 stat  output  4  new flags: [3]=C, [2]=V, [1]=N, [0]=Z.
REQ-012 stat_en  output  1  status-register load enable.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 wb_sel  output  1  write-back select.
REQ-015 write_data  output  32  register-file write data.
REQ-016 halted  output  1  HALT has been executed.

Function
REQ-017 Controller FSM states SHALL be START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK and HALT.
REQ-018 FSM sequence SHALL be START0->START1->FETCH->DECODE->EXECUTE->MEM->WRITEBACK->FETCH, one state per cycle; after reset, the first FETCH occurs 2 cycles after release.
REQ-019 Opcodes: 0000 NOP; 0001 reg-reg ALU (alu_op=00); 0010 reg-immediate add (alu_op=01); 1111 HALT; all others SHALL act as NOP.
REQ-020 stat_en SHALL be 1 only in EXECUTE for opcode 0001 or 0010, and only when the decoded function is valid.
REQ-021 rf_we SHALL be 1 only in WRITEBACK for opcode 0001 or 0010 with a valid function.
REQ-022 wb_sel SHALL be 0 for all opcodes defined here.
REQ-023 When a HALT opcode is in DECODE, the FSM SHALL enter the HALT state, drive halted=1, hold all enables at 0, and remain there until reset.
REQ-024 alu_op SHALL be driven from the opcode during DECODE through WRITEBACK, and SHALL be 00 otherwise.
REQ-025 alu_op=00 SHALL decode func (instruction[3:0]) with A=rsa and B=rsb as follows:
- 0001: ADD.
- 0010: SUB (A-B).
- 0011: NOT A.
- 0100: OR.
- 0101: AND.
- 0110: XOR.
- 0111: shift A left logical by B[4:0].
- 1000: shift A right logical by B[4:0].
- Any other func code: result 0 and the function is invalid (no stat_en, no rf_we).
REQ-026 alu_op=01 SHALL produce rsa + sign-extended imm.
REQ-027 alu_op=10 SHALL pass rsb through.
REQ-028 alu_op=11 SHALL produce 0.
REQ-029 Arithmetic SHALL be modulo 2^32.
REQ-030 C SHALL be the carry-out for ADD, and the NOT-borrow (A>=B unsigned) for SUB.
REQ-031 V SHALL be the signed overflow for ADD and SUB.
REQ-032 C and V SHALL be 0 for all other operations.
REQ-033 N SHALL equal result[31], and Z SHALL equal (result==0), for every operation.
REQ-034 write_data SHALL equal alu_result when wb_sel=0 and mem_data when wb_sel=1, combinationally.

Reset
REQ-035 A rising edge of clk with rst_f=1 SHALL force state START0 and drive rf_we=0, stat_en=0, alu_op=00, wb_sel=0 and halted=0.
REQ-036 Reset SHALL take precedence in every state, including mid-instruction and HALT; a partially executed instruction SHALL produce no rf_we pulse.
REQ-037 alu_result, stat and write_data SHALL remain combinational functions of their inputs during reset.

Verification
REQ-038 Reset, release, opcode 0001 func ADD, rsa=5, rsb=3: alu_result=8, stat=0000, stat_en high for exactly 1 cycle (EXECUTE), then rf_we high for 1 cycle (WRITEBACK) with write_data=8.
REQ-039 SUB with rsa=3, rsb=5: result=FFFFFFFE, stat=0010 (C=0, N=1); SUB with rsa=rsb=7: result=0, stat=1001.
REQ-040 ADD with rsa=7FFFFFFF, rsb=1: result=80000000, stat=0110; ADD with rsa=FFFFFFFF, rsb=1: result=0, stat=1001.
REQ-041 Opcode 0010, rsa=10, imm=FFFF: result=0000000F; NOP and func=1111 produce no stat_en and no rf_we over a full 5-cycle instruction.
REQ-042 HALT: halted=1 from the cycle after DECODE, enables stay 0 for 10+ cycles; asserting rst_f clears halted and restarts the FSM at START0.
